// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stall, taken-branch flush,
// mul/div EX occupancy, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             IdValid,
    input  logic [RA_W-1:0]  IdRs,
    input  logic [RA_W-1:0]  IdRt,
    input  logic             IdUseRs,
    input  logic             IdUseRt,
    input  logic             IdIsMd,
    input  logic             ExWreg,
    input  logic             ExM2reg,
    input  logic [RA_W-1:0]  ExRn,
    input  logic             BrTaken,
    output logic             PcEn,
    output logic             IfIdEn,
    output logic             IdExEn,
    output logic             IfIdFlushN,
    output logic             IdExFlushN,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic {
        ST_RUN,
        ST_MDBUSY
    } state_t;

    // Busy countdown loads MD_LAT-1 so the front end freezes MD_LAT-1 cycles after issue.
    localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             rs_hit, rt_hit, load_use;

    assign rs_hit   = IdUseRs && (IdRs == ExRn);
    assign rt_hit   = IdUseRt && (IdRt == ExRn);
    assign load_use = IdValid && ExM2reg && ExWreg && (ExRn != '0) && (rs_hit || rt_hit);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        PcEn       = 1'b1;
        IfIdEn     = 1'b1;
        IdExEn     = 1'b1;
        IfIdFlushN = 1'b1;
        IdExFlushN = 1'b1;
        MdBusy     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (Rst) begin
            PcEn       = 1'b0;
            IfIdEn     = 1'b0;
            IdExEn     = 1'b0;
            IfIdFlushN = 1'b0;
            IdExFlushN = 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (BrTaken) begin
                        // The ID instruction is wrong-path; clear both registers.
                        IfIdFlushN = 1'b0;
                        IdExFlushN = 1'b0;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        PcEn       = 1'b0;
                        IfIdEn     = 1'b0;
                        IdExFlushN = 1'b0;
                        stall_inc  = 1'b1;
                    end else if (IdValid && IdIsMd) begin
                        md_cnt_d = MD_INIT;
                        state_d  = ST_MDBUSY;
                    end
                end

                ST_MDBUSY: begin
                    // EX holds the mul/div op, so branch and load-use inputs are ignored.
                    PcEn      = 1'b0;
                    IfIdEn    = 1'b0;
                    IdExEn    = 1'b0;
                    MdBusy    = 1'b1;
                    stall_inc = 1'b1;
                    md_cnt_d  = md_cnt_q - 4'd1;
                    if (md_cnt_q == 4'd1) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the enable and flush inputs of the PC, the IF/ID register and the ID/EX register, which take a per-register En and an active-low clear.
- Resolves three hazard classes:
  - load-use stall;
  - taken-branch flush;
  - multi-cycle multiply/divide occupancy of EX.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_LAT, 4, cycles a mul/div op occupies EX (legal range 2..15).
- RA_W, 5, register-address width.
- CNT_W, 16, performance counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous reset, active-high.
- IdValid  in  1  ID stage holds a valid instruction.
- IdRs  in  RA_W  ID source register 1.
- IdRt  in  RA_W  ID source register 2.
- IdUseRs  in  1  ID instruction reads IdRs.
- IdUseRt  in  1  ID instruction reads IdRt.
- IdIsMd  in  1  ID instruction is mul/div.
- ExWreg  in  1  EX instruction writes the register file.
- ExM2reg  in  1  EX instruction is a load.
- ExRn  in  RA_W  EX destination register.
- BrTaken  in  1  branch resolved taken in EX this cycle.
- PcEn  out  1  PC update enable.
- IfIdEn  out  1  IF/ID enable.
- IdExEn  out  1  ID/EX enable.
- IfIdFlushN  out  1  IF/ID clear, active-low.
- IdExFlushN  out  1  ID/EX clear, active-low (bubble insert).
- MdBusy  out  1  FSM in MDBUSY.
- StallCnt  out  CNT_W  cycles with PcEn=0 outside reset.
- FlushCnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - state←RUN, md counter←0, StallCnt←0, FlushCnt←0.
  - While Rst=1: PcEn=IfIdEn=IdExEn=0, IfIdFlushN=IdExFlushN=0, MdBusy=0.
  - Reset mid-MDBUSY aborts the busy period immediately.
- Outputs are combinational from state and current inputs. No output depends on Rst except as stated above.
- Load-use detect: LU = IdValid & ExM2reg & ExWreg & (ExRn≠0) & ((IdUseRs & IdRs==ExRn) | (IdUseRt & IdRt==ExRn)).
- States: RUN, MDBUSY.
- RUN, evaluated in priority order:
  1. BrTaken=1 (flush): PcEn=1, IfIdEn=1, IdExEn=1, IfIdFlushN=0, IdExFlushN=0. FlushCnt+1. Stay RUN. Branch wins over LU and IdIsMd; the ID instruction is wrong-path and is discarded.
  2. LU=1 (stall): PcEn=0, IfIdEn=0, IdExEn=1, IdExFlushN=0 (bubble), IfIdFlushN=1. StallCnt+1. Stay RUN. The stall lasts exactly one cycle, because the load then leaves EX.
  3. IdValid & IdIsMd: normal advance (all En=1, flushes=1). Counter←MD_LAT-1. Next state MDBUSY.
  4. Otherwise: all En=1, IfIdFlushN=IdExFlushN=1.
- MDBUSY:
  - PcEn=IfIdEn=IdExEn=0, flushes=1 (front end holds, not cleared), MdBusy=1. StallCnt+1 each cycle.
  - Counter decrements each cycle. At counter==1, next state RUN.
  - Total front-end freeze = MD_LAT-1 cycles after the issue cycle.
  - BrTaken and LU are ignored in MDBUSY, since EX holds the mul/div op.
- Back-to-back mul/div: the second op issues on the first RUN cycle after MDBUSY. It is subject to LU and branch priority as usual.
- Counters saturate at 2^CNT_W-1; no wrap.
- IdValid=0 suppresses LU and mul/div issue. BrTaken still flushes.

Test Plan:
1. Rst=1 for 2 cycles, then 0 with no hazards → during reset all En=0 and both FlushN=0. First cycle after reset: PcEn=IfIdEn=IdExEn=1, FlushN=1, StallCnt=0, FlushCnt=0.
2. Load-use: ExM2reg=1, ExWreg=1, ExRn=5, IdRs=5, IdUseRs=1 for 1 cycle → that cycle PcEn=0, IfIdEn=0, IdExFlushN=0. Next cycle (ExM2reg=0) all En=1. StallCnt=1. Repeat with ExRn=0 → no stall.
3. Mul/div, MD_LAT=4: IdIsMd=1, IdValid=1 at cycle t → t normal advance. t+1..t+3 MdBusy=1 with all En=0. t+4 RUN with En=1. StallCnt=3.
4. BrTaken=1 coincident with LU=1 and IdIsMd=1 → IfIdFlushN=IdExFlushN=0, PcEn=1, no MDBUSY entry. FlushCnt=1, StallCnt unchanged.
5. Rst=1 asserted on the 2nd MDBUSY cycle → next cycle state RUN, MdBusy=0, counters 0.
6. CNT_W=4: hold LU=1 for 20 cycles → StallCnt saturates at 15.
